seq_pattern_gen: RTL and testbench

Upstream stimulus stage for the serial sequence detector. It accepts a WIDTH-bit pattern word over a valid/ready load handshake and serializes it LSB-first onto a single-bit stream. The stream runs at a programmable bit rate and can be sent once or rotated continuously. dout connects directly to the detector's din, and bit_stb marks each new bit for scoreboarding.

---
 rtl/seq_gen_pkg.sv | 14 +
 rtl/seq_bit_tick.sv | 37 +++
 rtl/seq_pattern_gen.sv | 145 ++++++++++++++
 tb/tb_seq_pattern_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator and the sequence
// detector bench: state encoding and the default test pattern.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Word the detector looks for; transmitted LSB first.
  localparam logic [9:0] DEFAULT_PATTERN = 10'b1001010110;

endpackage

// File: rtl/seq_bit_tick.sv
// Bit-rate divider: counts 0..DIV-1 while enabled and flags the last count,
// which is the cycle in which the generator emits the next serial bit.
module seq_bit_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serializes a WIDTH-bit pattern LSB first at a programmable bit rate,
// either once or rotated continuously until a stop request.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int   WIDTH      = 10,
  parameter int   DIV        = 1,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_repeat,
  input  logic             stop,
  output logic             dout,
  output logic             bit_stb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic               rep_q, rep_d;
  logic               stop_pend_q, stop_pend_d;
  logic               dout_q, dout_d;
  logic               bit_stb_q, bit_stb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

  logic accept;
  logic tick;

  assign accept = load_valid && (state_q == IDLE);

  seq_bit_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == SHIFT),
    .clr  (accept),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    rep_d       = rep_q;
    stop_pend_d = stop_pend_q;
    dout_d      = dout_q;
    bit_stb_d   = 1'b0;
    word_cnt_d  = word_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d        = load_data;
          rep_d       = load_repeat;
          bit_cnt_d   = '0;
          word_cnt_d  = '0;
          stop_pend_d = 1'b0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (tick) begin
          dout_d    = sr_q[0];
          // Rotating keeps the word intact so repeat mode needs no reload.
          sr_d      = {sr_q[0], sr_q[WIDTH-1:1]};
          bit_stb_d = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (word_cnt_q != {CNT_W{1'b1}}) begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
            // A stop arriving with the final tick still ends on this boundary.
            if (!(rep_q && !(stop_pend_q || stop))) begin
              state_d = DONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        dout_d  = IDLE_LEVEL;
      end
      default: begin
        state_d = IDLE;
        dout_d  = IDLE_LEVEL;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == SHIFT) && (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      rep_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      dout_q      <= IDLE_LEVEL;
      bit_stb_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_q       <= rep_d;
      stop_pend_q <= stop_pend_d;
      dout_q      <= dout_d;
      bit_stb_q   <= bit_stb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign dout       = dout_q;
  assign bit_stb    = bit_stb_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: one instance at DIV=1, one at DIV=4.
module tb_seq_pattern_gen;
  import seq_gen_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic       a_valid, a_ready, a_rep, a_stop, a_dout, a_stb, a_busy, a_done;
  logic [9:0] a_data;
  logic [7:0] a_wcnt;

  logic       b_valid, b_ready, b_rep, b_stop, b_dout, b_stb, b_busy, b_done;
  logic [9:0] b_data;
  logic [7:0] b_wcnt;

  int tests = 0;
  int fails = 0;

  // Hand-expanded LSB-first bit order of the words used below.
  int exp_bits[10] = '{0, 1, 1, 0, 1, 0, 1, 0, 0, 1};
  int w2_bits[10]  = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
  localparam logic [9:0] W2 = 10'b1100110011;

  always #5 clk = ~clk;

  seq_pattern_gen #(.WIDTH(10), .DIV(1), .IDLE_LEVEL(1'b0), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .load_valid(a_valid), .load_ready(a_ready),
    .load_data(a_data), .load_repeat(a_rep), .stop(a_stop), .dout(a_dout),
    .bit_stb(a_stb), .busy(a_busy), .done(a_done), .word_cnt(a_wcnt)
  );

  seq_pattern_gen #(.WIDTH(10), .DIV(4), .IDLE_LEVEL(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .load_valid(b_valid), .load_ready(b_ready),
    .load_data(b_data), .load_repeat(b_rep), .stop(b_stop), .dout(b_dout),
    .bit_stb(b_stb), .busy(b_busy), .done(b_done), .word_cnt(b_wcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int busy_cnt;
    int stb_cnt;
    logic exp_stb;
    logic exp_dout;

    rst = 1'b1;
    a_valid = 1'b0; a_data = '0; a_rep = 1'b0; a_stop = 1'b0;
    b_valid = 1'b0; b_data = '0; b_rep = 1'b0; b_stop = 1'b0;
    step(); step();
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_dout",  32'(a_dout),  32'd0);
    chk("rst_stb",   32'(a_stb),   32'd0);
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_done",  32'(a_done),  32'd0);
    chk("rst_wcnt",  32'(a_wcnt),  32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    rst = 1'b0;
    step();
    $display("[TB] reset checked");

    // 1: single word, DIV=1
    a_valid = 1'b1; a_data = DEFAULT_PATTERN; a_rep = 1'b0;
    step();
    a_valid = 1'b0;
    chk("t1_ready_low", 32'(a_ready), 32'd0);
    chk("t1_busy", 32'(a_busy), 32'd1);
    chk("t1_stb0", 32'(a_stb), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t1_bit%0d", i), 32'(a_dout), 32'(exp_bits[i]));
      chk($sformatf("t1_stb%0d", i), 32'(a_stb), 32'd1);
      chk($sformatf("t1_done%0d", i), 32'(a_done), (i == 9) ? 32'd1 : 32'd0);
    end
    chk("t1_wcnt_done", 32'(a_wcnt), 32'd1);
    chk("t1_ready_done", 32'(a_ready), 32'd0);
    step();
    chk("t1_done_clr", 32'(a_done), 32'd0);
    chk("t1_idle_dout", 32'(a_dout), 32'd0);
    chk("t1_ready", 32'(a_ready), 32'd1);
    chk("t1_busy_idle", 32'(a_busy), 32'd0);
    chk("t1_wcnt", 32'(a_wcnt), 32'd1);
    $display("[TB] test1 single word DIV=1 done");

    // 2: DIV=4; c counts cycles after the accept edge
    b_valid = 1'b1; b_data = DEFAULT_PATTERN; b_rep = 1'b0;
    step();
    b_valid = 1'b0;
    busy_cnt = 0;
    stb_cnt = 0;
    for (int c = 0; c < 45; c++) begin
      if (c > 0) step();
      busy_cnt += int'(b_busy);
      stb_cnt  += int'(b_stb);
      exp_stb  = (c >= 4) && (c <= 40) && (c % 4 == 0);
      exp_dout = (c >= 4 && c <= 40) ? exp_bits[c / 4 - 1][0] : 1'b0;
      chk($sformatf("t2_stb_c%0d", c), 32'(b_stb), 32'(exp_stb));
      chk($sformatf("t2_dout_c%0d", c), 32'(b_dout), 32'(exp_dout));
      if (c == 39 || c == 40 || c == 41)
        chk($sformatf("t2_done_c%0d", c), 32'(b_done), (c == 40) ? 32'd1 : 32'd0);
    end
    chk("t2_busy_cycles", 32'(busy_cnt), 32'd41);
    chk("t2_stb_count", 32'(stb_cnt), 32'd10);
    chk("t2_wcnt", 32'(b_wcnt), 32'd1);
    $display("[TB] test2 DIV=4 done");

    // 3: repeat, stop during word 3
    a_valid = 1'b1; a_data = DEFAULT_PATTERN; a_rep = 1'b1;
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      chk($sformatf("t3_bit%0d", i), 32'(a_dout), 32'(exp_bits[i % 10]));
      chk($sformatf("t3_stb%0d", i), 32'(a_stb), 32'd1);
      if (i == 9 || i == 19 || i == 29)
        chk($sformatf("t3_done%0d", i), 32'(a_done), (i == 29) ? 32'd1 : 32'd0);
      a_stop = (i == 23);
    end
    chk("t3_wcnt", 32'(a_wcnt), 32'd3);
    step();
    chk("t3_ready", 32'(a_ready), 32'd1);
    chk("t3_stb_idle", 32'(a_stb), 32'd0);
    $display("[TB] test3 repeat x3 with stop done");

    // 4: stop coincident with the last-bit tick of word 1
    a_valid = 1'b1; a_data = DEFAULT_PATTERN; a_rep = 1'b1;
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t4_bit%0d", i), 32'(a_dout), 32'(exp_bits[i]));
      a_stop = (i == 8);
    end
    chk("t4_done", 32'(a_done), 32'd1);
    chk("t4_wcnt", 32'(a_wcnt), 32'd1);
    step();
    chk("t4_ready", 32'(a_ready), 32'd1);
    step();
    chk("t4_no_more_bits", 32'(a_stb), 32'd0);
    $display("[TB] test4 stop on boundary done");

    // 5: asynchronous reset mid-word
    a_valid = 1'b1; a_data = DEFAULT_PATTERN; a_rep = 1'b0;
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("t5_pre_busy", 32'(a_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_busy", 32'(a_busy), 32'd0);
    chk("t5_async_ready", 32'(a_ready), 32'd1);
    chk("t5_async_dout", 32'(a_dout), 32'd0);
    chk("t5_async_stb", 32'(a_stb), 32'd0);
    chk("t5_async_wcnt", 32'(a_wcnt), 32'd0);
    step();
    chk("t5_no_done", 32'(a_done), 32'd0);
    rst = 1'b0;
    step();
    chk("t5_no_done2", 32'(a_done), 32'd0);
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t5_bit%0d", i), 32'(a_dout), 32'(exp_bits[i]));
    end
    chk("t5_done", 32'(a_done), 32'd1);
    step();
    $display("[TB] test5 reset mid-word done");

    // 6: load_valid held through SHIFT with a second word
    a_valid = 1'b1; a_data = DEFAULT_PATTERN; a_rep = 1'b0;
    step();
    a_data = W2;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t6_w1_bit%0d", i), 32'(a_dout), 32'(exp_bits[i]));
    end
    chk("t6_w1_done", 32'(a_done), 32'd1);
    step();
    chk("t6_ready_idle", 32'(a_ready), 32'd1);
    step();
    chk("t6_accepted", 32'(a_ready), 32'd0);
    a_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t6_w2_bit%0d", i), 32'(a_dout), 32'(w2_bits[i]));
    end
    chk("t6_w2_done", 32'(a_done), 32'd1);
    chk("t6_w2_wcnt", 32'(a_wcnt), 32'd1);
    step();
    $display("[TB] test6 held load_valid done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
